// File: rtl/reg_memory_bank.sv
// rtl/reg_memory_bank.sv - DEPTH x WIDTH word store with registered read port and hardware clear sweep
// Optional even-parity storage per word when REG_MEMORY_BANK_PARITY_EN is defined.
module reg_memory_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              clear,
  output logic              busy
`ifdef REG_MEMORY_BANK_PARITY_EN
  ,
  input  logic              wr_par_flip,
  output logic              rd_par_err
`endif
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_ok, rd_ok, clr_we;
  logic              wr_in_range, rd_in_range;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
  assign busy        = (state == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // A clear request wins over a write presented in the same cycle; reads still proceed.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    wr_ok      = 1'b0;
    rd_ok      = 1'b0;
    clr_we     = 1'b0;
    case (state)
      IDLE: begin
        rd_ok = rd_en;
        if (clear) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end else begin
          wr_ok = wr_en && wr_in_range;
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        if (ptr == LAST) begin
          state_next = IDLE;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[ptr] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Array read uses the pre-edge contents, giving read-before-write on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) rd_data <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

`ifdef REG_MEMORY_BANK_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) par_mem[i] <= 1'b0;
    end else if (clr_we) begin
      par_mem[ptr] <= 1'b0;
    end else if (wr_ok) begin
      par_mem[wr_addr] <= (^wr_data) ^ wr_par_flip;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_par_err <= 1'b0;
    end else begin
      rd_par_err <= rd_ok && rd_in_range && (par_mem[rd_addr] != (^mem[rd_addr]));
    end
  end
`endif

endmodule
